mdio_phy_ctrl: RTL and testbench

PHY management controller for the RGMII receive path. It waits for the PHY to leave reset, then writes the BMCR (reg 0) over MDIO to select speed or autonegotiation. After that it periodically polls BMSR (reg 1) and PHYSR (reg 17) and publishes link status and speed. The link speed output drives the 2-bit speed select used by the rx_top data-enable divider.

---
 rtl/mdio_phy_ctrl_if.sv | 26 ++
 rtl/mdio_phy_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_mdio_phy_ctrl.sv | 389 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdio_phy_ctrl_if.sv
// MDIO management bus between the PHY controller and its host / pin side.
// The master modport is the controller; the slave modport is the host and PHY pin side.
interface mdio_phy_ctrl_if;
    logic       phy_ready;
    logic [1:0] cfg_speed;
    logic       cfg_start;
    logic       mdio_i;
    logic       eth_mdc;
    logic       mdio_o;
    logic       mdio_oe;
    logic       link_up;
    logic [1:0] link_speed;
    logic       busy;
    logic       cfg_done;
    logic       mdio_err;

    modport master (
        input  phy_ready, cfg_speed, cfg_start, mdio_i,
        output eth_mdc, mdio_o, mdio_oe, link_up, link_speed, busy, cfg_done, mdio_err
    );

    modport slave (
        output phy_ready, cfg_speed, cfg_start, mdio_i,
        input  eth_mdc, mdio_o, mdio_oe, link_up, link_speed, busy, cfg_done, mdio_err
    );
endinterface

// File: rtl/mdio_phy_ctrl.sv
// PHY management controller: writes BMCR once the PHY is ready, then polls BMSR and PHYSR
// over MDIO and publishes link status and speed.
module mdio_phy_ctrl #(
    parameter int unsigned MDC_DIV       = 25,
    parameter logic [4:0]  PHY_ADDR      = 5'd1,
    parameter logic [23:0] POLL_INTERVAL = 24'd1250000
) (
    input  logic            clk125MHz,
    input  logic            resetn,
    mdio_phy_ctrl_if.master io_bus
);
    localparam int unsigned   DivW    = (MDC_DIV > 1) ? $clog2(MDC_DIV) : 1;
    localparam logic [DivW-1:0] DivMax = DivW'(MDC_DIV - 1);
    localparam logic [23:0]   PollMax = POLL_INTERVAL - 24'd1;

    typedef enum logic [2:0] {
        StWaitPhy, StWrBmcr, StPollWait, StRdBmsr, StRdPhysr, StUpdate
    } state_e;

    state_e          r_state;
    logic            r_active;
    logic            r_rd;
    logic [DivW-1:0] r_div;
    logic            r_mdc;
    logic [5:0]      r_bit;
    logic [63:0]     r_frame;
    logic            r_mdio_o;
    logic            r_mdio_oe;
    logic            r_busy;
    logic [15:0]     r_shift;
    logic [15:0]     r_bmsr;
    logic            r_ta_err;
    logic [23:0]     r_poll;
    logic            r_pend;
    logic            r_link_up;
    logic [1:0]      r_link_speed;
    logic            r_cfg_done;
    logic            r_mdio_err;

    logic            w_is_rd;
    logic [4:0]      w_reg;
    logic [15:0]     w_bmcr;
    logic [63:0]     w_word;
    logic            w_cfg_req;
    logic            w_launch;

    always_comb begin
        w_is_rd = (r_state != StWrBmcr);
        w_reg   = 5'd0;
        case (r_state)
            StRdBmsr:  w_reg = 5'd1;
            StRdPhysr: w_reg = 5'd17;
            default:   w_reg = 5'd0;
        endcase
        case (io_bus.cfg_speed)
            2'b11:   w_bmcr = 16'h1340;
            2'b10:   w_bmcr = 16'h0140;
            2'b01:   w_bmcr = 16'h2100;
            default: w_bmcr = 16'h0100;
        endcase
        // Read frames leave TA and data undriven, so their shift-out content is don't-care.
        w_word = {32'hFFFF_FFFF, 2'b01, (w_is_rd ? 2'b10 : 2'b01), PHY_ADDR, w_reg,
                  (w_is_rd ? 2'b11 : 2'b10), (w_is_rd ? 16'hFFFF : w_bmcr)};
        w_cfg_req = r_pend | io_bus.cfg_start;
        w_launch  = !r_active && ((r_state == StWrBmcr) ||
                    (((r_state == StRdBmsr) || (r_state == StRdPhysr)) && !w_cfg_req));
    end

    always_ff @(posedge clk125MHz or negedge resetn) begin
        if (!resetn) begin
            r_state      <= StWaitPhy;
            r_active     <= 1'b0;
            r_rd         <= 1'b0;
            r_div        <= '0;
            r_mdc        <= 1'b0;
            r_bit        <= 6'd0;
            r_frame      <= '1;
            r_mdio_o     <= 1'b1;
            r_mdio_oe    <= 1'b0;
            r_busy       <= 1'b0;
            r_shift      <= 16'd0;
            r_bmsr       <= 16'd0;
            r_ta_err     <= 1'b0;
            r_poll       <= 24'd0;
            r_pend       <= 1'b0;
            r_link_up    <= 1'b0;
            r_link_speed <= 2'b11;
            r_cfg_done   <= 1'b0;
            r_mdio_err   <= 1'b0;
        end else if (!io_bus.phy_ready) begin
            // Losing the PHY truncates any frame and forgets link and config state.
            r_state      <= StWaitPhy;
            r_active     <= 1'b0;
            r_mdc        <= 1'b0;
            r_mdio_o     <= 1'b1;
            r_mdio_oe    <= 1'b0;
            r_busy       <= 1'b0;
            r_pend       <= 1'b0;
            r_link_up    <= 1'b0;
            r_link_speed <= 2'b11;
            r_cfg_done   <= 1'b0;
        end else begin
            if (r_active) begin
                if (r_div != DivMax) begin
                    r_div <= r_div + 1'b1;
                end else begin
                    r_div <= '0;
                    if (!r_mdc) begin
                        r_mdc <= 1'b1;
                        if (r_rd && (r_bit == 6'd47) && io_bus.mdio_i) r_ta_err <= 1'b1;
                        if (r_rd && (r_bit >= 6'd48)) r_shift <= {r_shift[14:0], io_bus.mdio_i};
                    end else if (r_bit != 6'd63) begin
                        r_mdc     <= 1'b0;
                        r_bit     <= r_bit + 6'd1;
                        r_mdio_o  <= r_frame[62];
                        r_frame   <= {r_frame[62:0], 1'b1};
                        r_mdio_oe <= !r_rd || (r_bit < 6'd45);
                    end else begin
                        r_active  <= 1'b0;
                        r_mdc     <= 1'b0;
                        r_mdio_o  <= 1'b1;
                        r_mdio_oe <= 1'b0;
                        r_busy    <= 1'b0;
                        case (r_state)
                            StWrBmcr: begin
                                r_cfg_done <= 1'b1;
                                r_poll     <= 24'd0;
                                r_state    <= StPollWait;
                            end
                            StRdBmsr: begin
                                r_bmsr  <= r_shift;
                                r_state <= w_cfg_req ? StWrBmcr : StRdPhysr;
                            end
                            StRdPhysr: r_state <= w_cfg_req ? StWrBmcr : StUpdate;
                            default:   r_state <= StWaitPhy;
                        endcase
                    end
                end
            end else begin
                case (r_state)
                    StWaitPhy: r_state <= StWrBmcr;
                    StWrBmcr:  r_pend  <= 1'b0;
                    StPollWait: begin
                        if (w_cfg_req) begin
                            r_state <= StWrBmcr;
                        end else if (r_poll == PollMax) begin
                            r_state  <= StRdBmsr;
                            r_ta_err <= 1'b0;
                        end else begin
                            r_poll <= r_poll + 24'd1;
                        end
                    end
                    StRdBmsr, StRdPhysr: begin
                        if (w_cfg_req) r_state <= StWrBmcr;
                    end
                    StUpdate: begin
                        // r_shift still holds the PHYSR word from the frame just finished.
                        if (r_ta_err) begin
                            r_link_up    <= 1'b0;
                            r_link_speed <= 2'b11;
                            r_mdio_err   <= 1'b1;
                        end else begin
                            r_link_up    <= r_bmsr[2] & r_shift[10];
                            r_link_speed <= (r_bmsr[2] & r_shift[10]) ? r_shift[15:14] : 2'b11;
                        end
                        r_poll  <= 24'd0;
                        r_state <= StPollWait;
                    end
                    default: r_state <= StWaitPhy;
                endcase
                if (w_launch) begin
                    r_active  <= 1'b1;
                    r_rd      <= w_is_rd;
                    r_div     <= '0;
                    r_mdc     <= 1'b0;
                    r_bit     <= 6'd0;
                    r_frame   <= w_word;
                    r_mdio_o  <= w_word[63];
                    r_mdio_oe <= 1'b1;
                    r_busy    <= 1'b1;
                end
            end
            // Placed last so an accepted request wins over a same-cycle frame completion.
            if (io_bus.cfg_start && (r_state != StWaitPhy)) begin
                r_pend     <= 1'b1;
                r_cfg_done <= 1'b0;
                r_mdio_err <= 1'b0;
            end
        end
    end

    assign io_bus.eth_mdc    = r_mdc;
    assign io_bus.mdio_o     = r_mdio_o;
    assign io_bus.mdio_oe    = r_mdio_oe;
    assign io_bus.busy       = r_busy;
    assign io_bus.link_up    = r_link_up;
    assign io_bus.link_speed = r_link_speed;
    assign io_bus.cfg_done   = r_cfg_done;
    assign io_bus.mdio_err   = r_mdio_err;
endmodule

// File: tb/tb_mdio_phy_ctrl.sv
// Bench for mdio_phy_ctrl: a frame monitor and PHY register model on the MDIO pins,
// with per-scenario tasks checking frames and published link state.
module tb_mdio_phy_ctrl;
    localparam int unsigned MDC_DIV       = 2;
    localparam logic [4:0]  PHY_ADDR      = 5'd1;
    localparam logic [23:0] POLL_INTERVAL = 24'd40;
    localparam int          FRAME_CYC     = 128 * MDC_DIV;
    localparam logic [63:0] RD_OE         = 64'hFFFF_FFFF_FFFC_0000;

    typedef struct {
        logic [63:0] bits;
        logic [63:0] oe;
        int          n;
        int          start;
        int          stop;
    } frame_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   failures = 0;

    mdio_phy_ctrl_if io();

    mdio_phy_ctrl #(
        .MDC_DIV      (MDC_DIV),
        .PHY_ADDR     (PHY_ADDR),
        .POLL_INTERVAL(POLL_INTERVAL)
    ) dut (
        .clk125MHz(clk),
        .resetn   (resetn),
        .io_bus   (io)
    );

    always #4 clk = ~clk;

    // PHY model state
    logic        phy_drv = 1'b0;
    logic        phy_val = 1'b1;
    bit          phy_respond = 1'b1;
    logic [15:0] bmsr_val = 16'h796D;
    logic [15:0] physr_val = 16'hAC00;

    assign io.mdio_i = io.mdio_oe ? io.mdio_o : (phy_drv ? phy_val : 1'b1);

    // Frame monitor
    int          cyc = 0;
    logic        prev_busy = 1'b0;
    logic        prev_mdc = 1'b0;
    logic [63:0] cur_bits = '1;
    logic [63:0] cur_oe = '0;
    int          cur_n = 0;
    int          cur_start = 0;
    int          last_rise = -1;
    int          mdc_period = 0;
    frame_t      fq[$];

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (io.busy === 1'b1 && prev_busy !== 1'b1) begin
                cur_n = 0; cur_bits = '1; cur_oe = '0; cur_start = cyc;
            end
            if (io.eth_mdc === 1'b1 && prev_mdc !== 1'b1 && io.busy === 1'b1 && cur_n < 64) begin
                cur_bits[63-cur_n] = io.mdio_o;
                cur_oe[63-cur_n]   = io.mdio_oe;
                cur_n++;
                if (last_rise >= 0) mdc_period = cyc - last_rise;
                last_rise = cyc;
            end
            if (io.eth_mdc === 1'b0 && prev_mdc === 1'b1 && io.busy === 1'b1) begin
                logic [15:0] rv;
                bit          is_rd;
                is_rd = (cur_bits[31:28] == 4'b0110) && (cur_bits[27:23] == PHY_ADDR);
                rv = (cur_bits[22:18] == 5'd1) ? bmsr_val :
                     (cur_bits[22:18] == 5'd17) ? physr_val : 16'hFFFF;
                if (phy_respond && is_rd && cur_n == 47) begin
                    phy_drv = 1'b1; phy_val = 1'b0;
                end else if (phy_respond && is_rd && cur_n >= 48 && cur_n <= 63) begin
                    phy_drv = 1'b1; phy_val = rv[63-cur_n];
                end else begin
                    phy_drv = 1'b0;
                end
            end
            if (io.busy !== 1'b1 && prev_busy === 1'b1) begin
                frame_t f;
                f.bits = cur_bits; f.oe = cur_oe; f.n = cur_n; f.start = cur_start; f.stop = cyc;
                fq.push_back(f);
                phy_drv = 1'b0;
                last_rise = -1;
            end
            prev_busy = io.busy;
            prev_mdc  = io.eth_mdc;
        end
    end

    function automatic logic [15:0] bmcr_of(input logic [1:0] spd);
        case (spd)
            2'b11:   return 16'h1340;
            2'b10:   return 16'h0140;
            2'b01:   return 16'h2100;
            default: return 16'h0100;
        endcase
    endfunction

    function automatic logic [63:0] exp_frame(input bit rd, input logic [4:0] regad,
                                              input logic [15:0] data);
        return {32'hFFFF_FFFF, 2'b01, (rd ? 2'b10 : 2'b01), PHY_ADDR, regad,
                (rd ? 2'b00 : 2'b10), (rd ? 16'h0000 : data)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic get_frame(output frame_t f, output bit ok);
        int t;
        t = 0;
        ok = 1'b0;
        f.bits = '0; f.oe = '0; f.n = 0; f.start = 0; f.stop = 0;
        while (fq.size() == 0 && t < 3000) begin
            tick();
            t++;
        end
        if (fq.size() != 0) begin
            f = fq.pop_front();
            ok = 1'b1;
        end else begin
            checks++; failures++;
            $display("FAIL frame_timeout: no frame within %0d cycles", t);
        end
    endtask

    task automatic wait_bit(input int n);
        int t;
        t = 0;
        while (!(io.busy === 1'b1 && cur_n == n && io.eth_mdc === 1'b0) && t < 3000) begin
            tick();
            t++;
        end
        if (t >= 3000) begin
            checks++; failures++;
            $display("FAIL wait_bit: bit %0d never reached (cur_n=%0d)", n, cur_n);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        logic [9:0] act;
        act = {io.eth_mdc, io.mdio_o, io.mdio_oe, io.link_up, io.link_speed, io.busy,
               io.cfg_done, io.mdio_err, 1'b0};
        checks++;
        if (act !== 10'b0_1_0_0_11_0_0_0_0) begin
            failures++;
            $display("FAIL %s: {mdc,o,oe,up,spd,busy,done,err} got %b want 0100110000", tag, act);
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        check_reset_vals("reset_values");
        checks++;
        if (io.busy !== 1'b0) begin
            failures++; $display("FAIL reset_busy: got %b want 0", io.busy);
        end
        resetn = 1'b1;
        repeat (3) tick();
        check_reset_vals("idle_without_phy_ready");
    endtask

    task automatic test_write();
        frame_t f;
        bit     ok;
        io.cfg_speed = 2'b11;
        io.phy_ready = 1'b1;
        tick();
        checks++;
        if (io.cfg_done !== 1'b0) begin
            failures++; $display("FAIL write_done_early: got %b want 0", io.cfg_done);
        end
        get_frame(f, ok);
        checks++;
        if (f.n !== 64 || f.bits !== exp_frame(1'b0, 5'd0, 16'h1340)) begin
            failures++;
            $display("FAIL write_bits: n=%0d got %h want %h", f.n, f.bits,
                     exp_frame(1'b0, 5'd0, 16'h1340));
        end
        checks++;
        if (f.oe !== '1) begin
            failures++; $display("FAIL write_oe: got %h want all ones", f.oe);
        end
        checks++;
        if (f.stop - f.start != FRAME_CYC) begin
            failures++;
            $display("FAIL write_duration: got %0d want %0d", f.stop - f.start, FRAME_CYC);
        end
        checks++;
        if (mdc_period != 2 * MDC_DIV) begin
            failures++; $display("FAIL mdc_period: got %0d want %0d", mdc_period, 2 * MDC_DIV);
        end
        checks++;
        if (io.cfg_done !== 1'b1 || io.mdio_oe !== 1'b0 || io.mdio_o !== 1'b1 ||
            io.eth_mdc !== 1'b0) begin
            failures++;
            $display("FAIL write_after: done=%b oe=%b o=%b mdc=%b want 1 0 1 0",
                     io.cfg_done, io.mdio_oe, io.mdio_o, io.eth_mdc);
        end
    endtask

    task automatic check_round(input string tag, input logic [15:0] bmsr,
                               input logic [15:0] physr, input bit ta_bad);
        frame_t a, b;
        bit     ok;
        bit     up;
        logic [1:0] spd;
        get_frame(a, ok);
        get_frame(b, ok);
        checks++;
        if ((a.bits & RD_OE) !== (exp_frame(1'b1, 5'd1, 16'h0) & RD_OE) || a.oe !== RD_OE ||
            a.n !== 64) begin
            failures++;
            $display("FAIL %s_bmsr_frame: bits=%h oe=%h n=%0d want reg1 read oe=%h",
                     tag, a.bits, a.oe, a.n, RD_OE);
        end
        checks++;
        if ((b.bits & RD_OE) !== (exp_frame(1'b1, 5'd17, 16'h0) & RD_OE) || b.oe !== RD_OE ||
            b.n !== 64) begin
            failures++;
            $display("FAIL %s_physr_frame: bits=%h oe=%h n=%0d want reg17 read oe=%h",
                     tag, b.bits, b.oe, b.n, RD_OE);
        end
        checks++;
        if (b.start - a.stop != 1) begin
            failures++; $display("FAIL %s_gap: got %0d want 1", tag, b.start - a.stop);
        end
        repeat (3) tick();
        up  = !ta_bad && bmsr[2] && physr[10];
        spd = up ? physr[15:14] : 2'b11;
        checks++;
        if (io.link_up !== up || io.link_speed !== spd) begin
            failures++;
            $display("FAIL %s_link: up=%b spd=%b want up=%b spd=%b (bmsr=%h physr=%h)",
                     tag, io.link_up, io.link_speed, up, spd, bmsr, physr);
        end
    endtask

    task automatic test_poll();
        for (int r = 0; r < 4; r++) begin
            if (r > 0) begin
                bmsr_val  = 16'($urandom);
                physr_val = 16'($urandom);
                if (r == 1) begin bmsr_val[2] = 1'b1; physr_val[10] = 1'b1; end
                if (r == 2) physr_val[10] = 1'b0;
            end
            check_round("poll", bmsr_val, physr_val, 1'b0);
        end
    endtask

    task automatic test_ta_err();
        phy_respond = 1'b0;
        check_round("ta_err", bmsr_val, physr_val, 1'b1);
        checks++;
        if (io.mdio_err !== 1'b1) begin
            failures++; $display("FAIL ta_err_flag: got %b want 1", io.mdio_err);
        end
        phy_respond = 1'b1;
        bmsr_val  = 16'h796D;
        physr_val = 16'hAC00;
        check_round("ta_recover", bmsr_val, physr_val, 1'b0);
        checks++;
        if (io.mdio_err !== 1'b1) begin
            failures++; $display("FAIL ta_err_sticky: got %b want 1", io.mdio_err);
        end
    endtask

    task automatic test_cfg_mid();
        frame_t a, b;
        bit     ok;
        logic [1:0] spd;
        for (int k = 0; k < 3; k++) begin
            spd = (k == 0) ? 2'b01 : 2'($urandom_range(0, 3));
            fq.delete();
            wait_bit(20);
            io.cfg_speed = spd;
            io.cfg_start = 1'b1;
            tick();
            io.cfg_start = 1'b0;
            checks++;
            if (io.cfg_done !== 1'b0 || io.mdio_err !== 1'b0) begin
                failures++;
                $display("FAIL cfg_accept: done=%b err=%b want 0 0", io.cfg_done, io.mdio_err);
            end
            get_frame(a, ok);
            get_frame(b, ok);
            checks++;
            if ((a.bits & RD_OE) !== (exp_frame(1'b1, 5'd1, 16'h0) & RD_OE) || a.n !== 64) begin
                failures++;
                $display("FAIL cfg_read_intact: bits=%h n=%0d want full reg1 read", a.bits, a.n);
            end
            checks++;
            if (b.bits !== exp_frame(1'b0, 5'd0, bmcr_of(spd)) || b.n !== 64 ||
                b.start - a.stop != 1) begin
                failures++;
                $display("FAIL cfg_write: bits=%h n=%0d gap=%0d want %h n=64 gap=1", b.bits, b.n,
                         b.start - a.stop, exp_frame(1'b0, 5'd0, bmcr_of(spd)));
            end
            checks++;
            if (io.cfg_done !== 1'b1) begin
                failures++; $display("FAIL cfg_done_after: got %b want 1", io.cfg_done);
            end
        end
    endtask

    task automatic test_phy_drop();
        frame_t f;
        bit     ok;
        logic [1:0] spd;
        wait_bit(50);
        checks++;
        if (io.link_up !== 1'b1 || io.mdio_oe !== 1'b0) begin
            failures++;
            $display("FAIL drop_before: up=%b oe=%b want 1 0", io.link_up, io.mdio_oe);
        end
        io.phy_ready = 1'b0;
        tick();
        checks++;
        if (io.eth_mdc !== 1'b0 || io.mdio_oe !== 1'b0 || io.mdio_o !== 1'b1 ||
            io.busy !== 1'b0 || io.link_up !== 1'b0 || io.link_speed !== 2'b11 ||
            io.cfg_done !== 1'b0) begin
            failures++;
            $display("FAIL drop_next: mdc=%b oe=%b o=%b busy=%b up=%b spd=%b done=%b",
                     io.eth_mdc, io.mdio_oe, io.mdio_o, io.busy, io.link_up, io.link_speed,
                     io.cfg_done);
        end
        repeat (4) tick();
        fq.delete();
        spd = 2'($urandom_range(0, 3));
        io.cfg_speed = spd;
        io.phy_ready = 1'b1;
        get_frame(f, ok);
        checks++;
        if (f.bits !== exp_frame(1'b0, 5'd0, bmcr_of(spd)) || f.n !== 64) begin
            failures++;
            $display("FAIL drop_rewrite: bits=%h n=%0d want %h", f.bits, f.n,
                     exp_frame(1'b0, 5'd0, bmcr_of(spd)));
        end
    endtask

    task automatic test_async_reset();
        frame_t f;
        bit     ok;
        io.cfg_speed = 2'b11;
        io.cfg_start = 1'b1;
        tick();
        io.cfg_start = 1'b0;
        wait_bit(10);
        @(negedge clk);
        #1 resetn = 1'b0;
        #1 check_reset_vals("async_reset");
        #1 resetn = 1'b1;
        tick();
        tick();
        fq.delete();
        get_frame(f, ok);
        checks++;
        if (f.bits !== exp_frame(1'b0, 5'd0, 16'h1340) || f.n !== 64 ||
            f.stop - f.start != FRAME_CYC) begin
            failures++;
            $display("FAIL reset_rewrite: bits=%h n=%0d dur=%0d want %h 64 %0d", f.bits, f.n,
                     f.stop - f.start, exp_frame(1'b0, 5'd0, 16'h1340), FRAME_CYC);
        end
    endtask

    initial begin
        io.phy_ready = 1'b0;
        io.cfg_speed = 2'b11;
        io.cfg_start = 1'b0;
        test_reset();
        test_write();
        test_poll();
        test_ta_err();
        test_cfg_mid();
        test_phy_drop();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
